cpu_trace_buffer: RTL and testbench
===================================

// Module: cpu_trace_buffer
// PURPOSE
// - Parametrised, synthesizable successor to the m_cpu bench probes: captures per-instruction
//   commit records {pc, instruction, ALU result} from the CPU into a circular buffer.
// - Freezes a pre/post window around a PC-match trigger, then plays records out oldest-first.
// - Sits beside m_cpu on the debug path; bench or host reads it after the CPU run.
// PARAMETERS
// - DATA_W     32  width of pc, instruction and result fields
// - DEPTH      16  records stored; power of two, >= 2
// - POST_TRIG  8   records kept after the trigger record; 0 <= POST_TRIG <= DEPTH-1
// PORTS
// - clk         in   1         rising-edge clock
// - rst         in   1         synchronous reset, active-high
// - arm         in   1         pulse: clear buffer, enter ARMED (honoured in any state)
// - trig_en     in   1         enables PC-match trigger
// - trig_pc     in   DATA_W    trigger address
// - cap_valid   in   1         commit strobe: cap_* sampled this cycle
// - cap_pc      in   DATA_W    committed pc
// - cap_instr   in   DATA_W    committed instruction
// - cap_result  in   DATA_W    ALU result register value
// - rd_req      in   1         request next record (DONE only)
// - rd_valid    out  1         rd_data valid this cycle
// - rd_data     out  3*DATA_W  {pc, instr, result}
// - rd_last     out  1         with rd_valid: final stored record
// - triggered   out  1         trigger seen since last arm
// - done        out  1         capture frozen
// - count       out  log2(DEPTH)+1  records held, saturates at DEPTH
// BEHAVIOUR
// - Reset: state IDLE; wr_ptr, rd_ptr, count, post_cnt = 0; all outputs 0.
// - States: IDLE -> ARMED on arm; ARMED -> POST on trigger; POST -> DONE when post_cnt
//   reaches POST_TRIG; DONE -> ARMED on arm. arm in ARMED/POST restarts capture with an
//   empty buffer (count=0, triggered=0).
// - Capture (ARMED, POST): each cap_valid writes a record at wr_ptr, wr_ptr wraps mod DEPTH,
//   count increments and saturates at DEPTH (oldest overwritten). cap_valid is ignored in IDLE/DONE.
// - Trigger: in ARMED, cap_valid & trig_en & cap_pc==trig_pc. The triggering record is
//   stored; triggered=1 the next cycle.
// - POST_TRIG=0: go directly to DONE.
// - Otherwise: enter POST; every further cap_valid increments post_cnt; the record that makes
//   post_cnt==POST_TRIG is stored and the state is DONE the next cycle.
// - Trigger before buffer full: window holds only count records; no padding.
// - DONE: done=1.
// - On entry, the read pointer is set to the oldest record:
//   - rd_ptr = wr_ptr - count (mod DEPTH).
// - Readout: rd_req in DONE with records remaining -> rd_valid=1 exactly one cycle later.
//   - rd_data is the record at rd_ptr; rd_ptr advances.
//   - rd_last=1 on the count-th record.
// - rd_req after the last record, or outside DONE, is ignored (rd_valid stays 0).
// - Back-to-back rd_req gives one record per cycle.
// - arm with cap_valid in the same cycle: arm wins; that record is not stored.
// - Reset mid-capture or mid-readout aborts immediately to the reset state.
// - Stored contents need no clearing.
// STRUCTURE
// - Shared package cpu_dbg_pkg:
//   - state encodings IDLE/ARMED/POST/DONE
//   - record width macro REC_W = 3*DATA_W
// - One sub-module trace_ram: simple dual-port, DEPTH x REC_W.
//   - Synchronous write, registered read (1-cycle latency), inferred RAM.
// - Top level holds the FSM, pointers, counters and the trigger comparator.
// TESTING (DATA_W=32, DEPTH=8, POST_TRIG=3)
// - Reset, 5 cap_valid without arm -> count=0, done=0, rd_req yields no rd_valid.
// - Pre-fill wrap:
//   - Stimulus: arm; 12 commits pc=0x00,0x04..0x2C; trig_pc=0x24 (10th commit); 3 more commits.
//   - Result: done=1, count=8.
//   - Readout pcs are 0x14..0x30 in order; rd_last with pc 0x30.
// - Early trigger:
//   - Stimulus: arm; trig_pc=0x00 matches the first commit; 3 more commits.
//   - Result: done=1, count=4.
//   - Four records are read (pc 0x00..0x0C); a 5th rd_req gives rd_valid=0.
// - Latency: rd_req held 8 cycles in DONE.
//   - rd_valid high on cycles 1..8 after the first request.
//   - rd_data matches the model each cycle.
// - arm during POST after 1 post record -> count=0, triggered=0, state ARMED; re-trigger captures cleanly.
// - rst asserted mid-readout (after 3 records) -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared state encoding and record sizing for the CPU debug trace path.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    function automatic int rec_w(input int data_w);
        return 3 * data_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port record store, synchronous write, registered read.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 96
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular commit-record capture with PC-match trigger window and
// oldest-first readout.
module cpu_trace_buffer
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       trig_en,
    input  logic [DATA_W-1:0]          trig_pc,
    input  logic                       cap_valid,
    input  logic [DATA_W-1:0]          cap_pc,
    input  logic [DATA_W-1:0]          cap_instr,
    input  logic [DATA_W-1:0]          cap_result,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [3*DATA_W-1:0]        rd_data,
    output logic                       rd_last,
    output logic                       triggered,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = rec_w(DATA_W);

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr, rd_ptr, wr_nxt;
    logic [CW-1:0]   cnt_nxt, rd_left, post_cnt;
    logic            cap_en, hit, post_hit, rd_fire, enter_done;
    logic [REC_W-1:0] q;

    // arm takes priority over a same-cycle commit, so that record is dropped
    assign cap_en     = cap_valid && !arm && (state == ARMED || state == POST);
    assign hit        = cap_en && state == ARMED && trig_en && cap_pc == trig_pc;
    assign post_hit   = cap_en && state == POST && post_cnt + CW'(1) == CW'(POST_TRIG);
    assign rd_fire    = state == DONE && !arm && rd_req && rd_left != '0;
    assign wr_nxt     = cap_en ? wr_ptr + AW'(1) : wr_ptr;
    assign cnt_nxt    = cap_en && count != CW'(DEPTH) ? count + CW'(1) : count;
    assign enter_done = state != DONE && state_nxt == DONE;
    assign done       = state == DONE;
    assign rd_data    = rd_valid ? q : '0;

    always_comb begin
        state_nxt = state;
        if (arm) state_nxt = ARMED;
        else if (hit) state_nxt = POST_TRIG == 0 ? DONE : POST;
        else if (post_hit) state_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            rd_left   <= '0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            rd_last  <= rd_fire && rd_left == CW'(1);
            if (arm) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                post_cnt  <= '0;
                rd_left   <= '0;
                triggered <= 1'b0;
            end else begin
                wr_ptr <= wr_nxt;
                count  <= cnt_nxt;
                if (hit) triggered <= 1'b1;
                if (cap_en && state == POST) post_cnt <= post_cnt + CW'(1);
                // a full buffer has cnt_nxt[AW-1:0]==0, so the oldest record sits at wr_nxt
                if (enter_done) begin
                    rd_ptr  <= wr_nxt - cnt_nxt[AW-1:0];
                    rd_left <= cnt_nxt;
                end else if (rd_fire) begin
                    rd_ptr  <= rd_ptr + AW'(1);
                    rd_left <= rd_left - CW'(1);
                end
            end
        end
    end

    trace_ram #(.DEPTH(DEPTH), .W(REC_W)) u_ram (
        .clk   (clk),
        .we    (cap_en),
        .waddr (wr_ptr),
        .wdata ({cap_pc, cap_instr, cap_result}),
        .re    (rd_fire),
        .raddr (rd_ptr),
        .rdata (q)
    );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed scenario tests for cpu_trace_buffer (DEPTH=8, POST_TRIG=3).
module tb_cpu_trace_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int PT    = 3;

    logic clk = 1'b0, rst = 1'b1, arm = 1'b0, trig_en = 1'b0, cap_valid = 1'b0, rd_req = 1'b0;
    logic [DW-1:0] trig_pc = '0, cap_pc = '0, cap_instr = '0, cap_result = '0;
    logic rd_valid, rd_last, triggered, done;
    logic [3*DW-1:0] rd_data;
    logic [$clog2(DEPTH):0] count;
    int errors = 0, checks = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(PT)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .cap_valid  (cap_valid),
        .cap_pc     (cap_pc),
        .cap_instr  (cap_instr),
        .cap_result (cap_result),
        .rd_req     (rd_req),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .triggered  (triggered),
        .done       (done),
        .count      (count)
    );

    function automatic logic [DW-1:0] instr_of(input logic [DW-1:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    function automatic logic [DW-1:0] res_of(input logic [DW-1:0] pc);
        return pc + 32'h0000_1000;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [DW-1:0] pc);
        cap_valid  = 1'b1;
        cap_pc     = pc;
        cap_instr  = instr_of(pc);
        cap_result = res_of(pc);
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic do_arm;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // rd_req held: one record per cycle starting one cycle after the request, then one extra request
    task automatic read_burst(input string name, input int n);
        logic [3*DW-1:0] want;
        rd_req = 1'b1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s lat0: rd_valid=%b want 0", name, rd_valid);
        end
        for (int i = 0; i < n; i++) begin
            tick();
            want = {exp_q[i], instr_of(exp_q[i]), res_of(exp_q[i])};
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== want || rd_last !== (i == n - 1)) begin
                errors++;
                $display("FAIL %s rec%0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                         name, i, rd_valid, rd_data, rd_last, want, i == n - 1);
            end
        end
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s extra_req: rd_valid=%b want 0", name, rd_valid);
        end
    endtask

    task automatic test_reset;
        repeat (2) tick();
        rst = 1'b0;
        checks++;
        if ({rd_valid, rd_last, triggered, done} !== 4'b0 || count !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b last=%b trig=%b done=%b count=%0d data=%h want all 0",
                     rd_valid, rd_last, triggered, done, count, rd_data);
        end
        trig_en = 1'b1;
        trig_pc = 32'h0;
        for (int i = 0; i < 5; i++) commit(32'(4 * i));
        checks++;
        if (count !== '0 || done !== 1'b0 || triggered !== 1'b0) begin
            errors++;
            $display("FAIL idle_capture: count=%0d done=%b trig=%b want 0 0 0", count, done, triggered);
        end
        rd_req = 1'b1;
        repeat (2) tick();
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_read: rd_valid=%b want 0", rd_valid);
        end
    endtask

    task automatic test_prefill_wrap;
        trig_en = 1'b1;
        trig_pc = 32'h24;
        do_arm();
        for (int i = 0; i < 10; i++) commit(32'(4 * i));
        checks++;
        if (triggered !== 1'b1 || done !== 1'b0 || count !== 4'd8) begin
            errors++;
            $display("FAIL wrap_trig: trig=%b done=%b count=%0d want 1 0 8", triggered, done, count);
        end
        for (int i = 10; i < 13; i++) commit(32'(4 * i));
        checks++;
        if (done !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL wrap_done: done=%b count=%0d want 1 8", done, count);
        end
        commit(32'h99);
        checks++;
        if (count !== 4'd8 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_capture: count=%0d done=%b want 8 1", count, done);
        end
        exp_q = {};
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h14 + 32'(4 * i));
        read_burst("wrap_latency", 8);
    endtask

    task automatic test_early_trigger;
        trig_pc = 32'h0;
        do_arm();
        commit(32'h0);
        checks++;
        if (triggered !== 1'b1 || done !== 1'b0 || count !== 4'd1) begin
            errors++;
            $display("FAIL early_trig: trig=%b done=%b count=%0d want 1 0 1", triggered, done, count);
        end
        for (int i = 1; i < 4; i++) commit(32'(4 * i));
        checks++;
        if (done !== 1'b1 || count !== 4'd4) begin
            errors++;
            $display("FAIL early_done: done=%b count=%0d want 1 4", done, count);
        end
        exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
        read_burst("early_read", 4);
    endtask

    task automatic test_arm_in_post;
        trig_pc = 32'h40;
        do_arm();
        commit(32'h38);
        commit(32'h3C);
        commit(32'h40);
        commit(32'h44);
        checks++;
        if (triggered !== 1'b1 || done !== 1'b0 || count !== 4'd4) begin
            errors++;
            $display("FAIL post_state: trig=%b done=%b count=%0d want 1 0 4", triggered, done, count);
        end
        arm = 1'b1;
        commit(32'h40);
        arm = 1'b0;
        checks++;
        if (triggered !== 1'b0 || done !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL rearm: trig=%b done=%b count=%0d want 0 0 0", triggered, done, count);
        end
        commit(32'h100);
        checks++;
        if (triggered !== 1'b0 || count !== 4'd1) begin
            errors++;
            $display("FAIL rearm_armed: trig=%b count=%0d want 0 1", triggered, count);
        end
        commit(32'h40);
        commit(32'h104);
        commit(32'h108);
        commit(32'h10C);
        checks++;
        if (done !== 1'b1 || triggered !== 1'b1 || count !== 4'd5) begin
            errors++;
            $display("FAIL retrig_done: done=%b trig=%b count=%0d want 1 1 5", done, triggered, count);
        end
        exp_q = {32'h100, 32'h40, 32'h104, 32'h108, 32'h10C};
        read_burst("retrig_read", 5);
    endtask

    task automatic test_reset_mid_read;
        trig_pc = 32'h0;
        do_arm();
        for (int i = 0; i < 4; i++) commit(32'(4 * i));
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data[3*DW-1:2*DW] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL mid_read%0d: valid=%b pc=%h want 1 %h", i, rd_valid,
                         rd_data[3*DW-1:2*DW], 32'(4 * i));
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({rd_valid, rd_last, triggered, done} !== 4'b0 || count !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b last=%b trig=%b done=%b count=%0d data=%h want all 0",
                     rd_valid, rd_last, triggered, done, count, rd_data);
        end
        rd_req = 1'b0;
        rst = 1'b0;
        commit(32'h0);
        checks++;
        if (count !== '0 || triggered !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: count=%0d trig=%b done=%b want 0 0 0", count, triggered, done);
        end
    endtask

    initial begin
        test_reset();
        test_prefill_wrap();
        test_early_trigger();
        test_arm_in_post();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
